prog_sequencer: RTL and testbench

Batch run controller that sits directly upstream of the processor top level and drives its Start and Reset pins while consuming its Ack. On a single Go request it resets the processor once, launches NUM_PROGS programs back to back, and measures the clock cycles each program takes to raise Ack. It reports each count with a one-cycle valid strobe and recovers from hung programs with a timeout.

---
 rtl/prog_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_prog_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// ============================================================================
// prog_sequencer
// ----------------------------------------------------------------------------
// Batch run controller sitting directly upstream of a processor top level.
// A single Go request resets the processor once, then launches NUM_PROGS
// programs back to back. For each program it counts the clock cycles until
// the processor raises its Ack, and reports that count with a one-cycle
// strobe. A program that never acknowledges is aborted after TIMEOUT RUN
// cycles and the processor is re-reset before the next program is launched.
//
// Parameters
//   NUM_PROGS  programs per batch (1..16)
//   CNT_W      cycle-counter width
//   TIMEOUT    maximum RUN cycles before abort (2 .. 2**CNT_W-1)
//   IDX_W      derived program-index width, max(1, $clog2(NUM_PROGS))
//
// Ports
//   Clk         in   system clock, posedge only
//   Reset       in   asynchronous, active-low reset
//   Go          in   batch request, sampled at posedge
//   DutAck      in   processor done flag
//   DutReset    out  processor reset, active high (high while Reset is low)
//   DutStart    out  one-cycle processor start pulse
//   ProgIdx     out  index of the current or last-run program
//   CycleCt     out  measured cycle count, held until the next report
//   CycleValid  out  one-cycle strobe qualifying CycleCt/ProgIdx/TimedOut
//   TimedOut    out  the reported program hit TIMEOUT
//   Busy        out  a batch is in progress
//   Done        out  sticky batch-complete flag
//   DbgState    out  current FSM state encoding (observation only)
//
// Every output comes straight from a flop; no input reaches an output
// combinationally.
// ============================================================================
module prog_sequencer #(
    parameter  int NUM_PROGS = 3,
    parameter  int CNT_W     = 16,
    parameter  int TIMEOUT   = (2 ** CNT_W) - 1,
    localparam int IDX_W     = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Go,
    input  logic             DutAck,
    output logic             DutReset,
    output logic             DutStart,
    output logic [IDX_W-1:0] ProgIdx,
    output logic [CNT_W-1:0] CycleCt,
    output logic             CycleValid,
    output logic             TimedOut,
    output logic             Busy,
    output logic             Done,
    output logic [2:0]       DbgState
);

    // Strobe semantics: CycleValid is a plain one-cycle strobe with no
    // back-pressure. ProgIdx, CycleCt and TimedOut are stable in the cycle
    // CycleValid is high; a consumer that misses the strobe has lost the
    // report (CycleCt and TimedOut do stay held until the next report).

    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX_C = IDX_W'(NUM_PROGS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RST    = 3'd1,
        S_START  = 3'd2,
        S_RUN    = 3'd3,
        S_REPORT = 3'd4
    } state_e;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_e             state_q,     state_d;
    logic               rst_sub_q,   rst_sub_d;   // RST phase sub-count
    logic [CNT_W-1:0]   cnt_q,       cnt_d;       // RUN cycle counter
    logic [IDX_W-1:0]   idx_q,       idx_d;
    logic [CNT_W-1:0]   ct_q,        ct_d;
    logic               to_q,        to_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;

    // Registered versions of the state-decoded outputs. They are loaded
    // from the next state so they line up with the state they describe
    // while still coming directly from flops.
    logic               dut_rst_q,   dut_rst_d;
    logic               dut_start_q, dut_start_d;
    logic               valid_q,     valid_d;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        rst_sub_d = rst_sub_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        ct_d      = ct_q;
        to_d      = to_q;
        busy_d    = busy_q;
        done_d    = done_q;

        case (state_q)
            S_IDLE: begin
                // Go is only sampled here, so requests during a batch or in
                // the REPORT cycle where Done rises are naturally ignored.
                if (Go) begin
                    state_d   = S_RST;
                    rst_sub_d = 1'b0;
                    done_d    = 1'b0;
                    idx_d     = '0;
                    busy_d    = 1'b1;
                end
            end

            S_RST: begin
                // Two cycles of processor reset, tracked by a 1-bit sub-count.
                if (rst_sub_q) begin
                    state_d   = S_START;
                    rst_sub_d = 1'b0;
                end else begin
                    rst_sub_d = 1'b1;
                end
            end

            S_START: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end

            S_RUN: begin
                // The counter is zero only in the first RUN cycle, so it
                // doubles as the first-cycle marker. An Ack seen then may be
                // left over from the previous program and is ignored.
                if (cnt_q == '0) begin
                    cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
                end else if (DutAck) begin
                    state_d = S_REPORT;
                    ct_d    = cnt_q;
                    to_d    = 1'b0;
                end else if (cnt_q == TIMEOUT_C) begin
                    state_d = S_REPORT;
                    ct_d    = cnt_q;
                    to_d    = 1'b1;
                end else begin
                    // TIMEOUT never exceeds the counter range, so this
                    // increment cannot wrap.
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_REPORT: begin
                if (idx_q == LAST_IDX_C) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                    // A hung processor is re-reset before the next program;
                    // a healthy one simply gets the next start pulse.
                    if (to_q) begin
                        state_d   = S_RST;
                        rst_sub_d = 1'b0;
                    end else begin
                        state_d = S_START;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        dut_rst_d   = (state_d == S_RST);
        dut_start_d = (state_d == S_START);
        valid_d     = (state_d == S_REPORT);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= S_IDLE;
            rst_sub_q   <= 1'b0;
            cnt_q       <= '0;
            idx_q       <= '0;
            ct_q        <= '0;
            to_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            // The processor is held in reset while this block is in reset.
            dut_rst_q   <= 1'b1;
            dut_start_q <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_sub_q   <= rst_sub_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            ct_q        <= ct_d;
            to_q        <= to_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dut_rst_q   <= dut_rst_d;
            dut_start_q <= dut_start_d;
            valid_q     <= valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign DutReset   = dut_rst_q;
    assign DutStart   = dut_start_q;
    assign ProgIdx    = idx_q;
    assign CycleCt    = ct_q;
    assign CycleValid = valid_q;
    assign TimedOut   = to_q;
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign DbgState   = state_q;

endmodule

// File: tb/tb_prog_sequencer.sv
module tb_prog_sequencer;

  localparam int NP = 3;
  localparam int CW = 16;
  localparam int TO = 20;
  localparam int IW = 2;
  localparam int EW = IW + CW + 1;
  localparam int NB = 5;

  // ---------------- clock / reset ----------------
  logic Clk    = 1'b0;
  logic Reset  = 1'b1;
  logic Go     = 1'b0;
  logic DutAck = 1'b0;

  logic          DutReset, DutStart, CycleValid, TimedOut, Busy, Done;
  logic [IW-1:0] ProgIdx;
  logic [CW-1:0] CycleCt;
  logic [2:0]    DbgState;

  always #5 Clk = ~Clk;

  prog_sequencer #(
    .NUM_PROGS (NP),
    .CNT_W     (CW),
    .TIMEOUT   (TO)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Go         (Go),
    .DutAck     (DutAck),
    .DutReset   (DutReset),
    .DutStart   (DutStart),
    .ProgIdx    (ProgIdx),
    .CycleCt    (CycleCt),
    .CycleValid (CycleValid),
    .TimedOut   (TimedOut),
    .Busy       (Busy),
    .Done       (Done),
    .DbgState   (DbgState)
  );

  // ---------------- vector table ----------------
  // ack_at: RUN cycle from which the processor model raises Ack (0 = never).
  // stale : do not drop a leftover Ack when this program is started.
  typedef struct {
    int            ack_at;
    bit            stale;
    logic [IW-1:0] idx;
    logic [CW-1:0] ct;
    bit            to;
  } vec_t;

  vec_t vecs [NB*NP];
  vec_t cur  [NP];

  // ---------------- scoreboard / bookkeeping ----------------
  logic [EW-1:0] exp_q [$];
  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int prog_ptr = 0;
  int run_cyc  = 0;
  int cur_ack  = 0;
  bit active   = 1'b0;
  bit ack_force = 1'b0;

  int rst_rises = 0;
  int rst_cycles = 0;
  bit prev_rst = 1'b0;
  bit have_last = 1'b0;
  bit last_to = 1'b0;
  int last_valid_cyc = 0;
  int first_start_cyc = -1;
  int first_valid_cyc = -1;
  int go_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    logic [EW-1:0] e;
    logic [EW-1:0] got;
    if (DutReset) begin
      rst_cycles++;
      if (!prev_rst) rst_rises++;
    end
    prev_rst = DutReset;

    if (DutStart) begin
      if (first_start_cyc < 0) first_start_cyc = cyc;
      if (have_last) begin
        chk("start_gap", cyc - last_valid_cyc, last_to ? 3 : 1);
        have_last = 1'b0;
      end
    end

    if (CycleValid) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got idx=%0d ct=%0d to=%0d expected no strobe (cycle %0d)",
                 ProgIdx, CycleCt, TimedOut, cyc);
      end else begin
        e   = exp_q.pop_front();
        got = {ProgIdx, CycleCt, TimedOut};
        if (got !== e) begin
          errors++;
          $display("FAIL strobe: got idx=%0d ct=%0d to=%0d expected idx=%0d ct=%0d to=%0d (cycle %0d)",
                   ProgIdx, CycleCt, TimedOut, e[EW-1 -: IW], e[CW:1], e[0], cyc);
        end
        last_to        = e[0];
        last_valid_cyc = cyc;
        have_last      = 1'b1;
      end
    end
  endtask

  // Behavioural processor: acknowledges each program at its table cycle.
  task automatic respond();
    if (!Busy) prog_ptr = 0;
    if (ack_force) begin
      DutAck = 1'b1;
      return;
    end
    if (DutReset) begin
      DutAck = 1'b0;
      active = 1'b0;
    end else if (DutStart) begin
      active  = 1'b1;
      run_cyc = 0;
      if (prog_ptr < NP) begin
        cur_ack = cur[prog_ptr].ack_at;
        if (!cur[prog_ptr].stale) DutAck = 1'b0;
      end
      prog_ptr++;
    end else if (active) begin
      run_cyc++;
      if (cur_ack != 0 && run_cyc >= cur_ack) DutAck = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    cyc++;
    monitor();
    respond();
  endtask

  task automatic run_batch(input int b, input int pulse_at, input bit go_at_done);
    int n;
    int exp_rises;
    exp_rises = 1;
    exp_q.delete();
    for (int p = 0; p < NP; p++) begin
      cur[p] = vecs[b*NP+p];
      exp_q.push_back({vecs[b*NP+p].idx, vecs[b*NP+p].ct, vecs[b*NP+p].to});
      if (p < NP-1 && vecs[b*NP+p].to) exp_rises++;
    end
    rst_rises = 0;
    rst_cycles = 0;
    have_last = 1'b0;
    first_start_cyc = -1;
    first_valid_cyc = -1;
    go_cyc = cyc;

    Go = 1'b1;
    tick();
    Go = 1'b0;
    chk("go_busy", Busy, 1);
    chk("go_done_clear", Done, 0);
    chk("go_idx", ProgIdx, 0);
    chk("go_dutreset", DutReset, 1);

    n = 0;
    while (!(Done && !Busy) && n < 500) begin
      if (n == pulse_at) Go = 1'b1;
      tick();
      Go = 1'b0;
      n++;
      if (go_at_done && CycleValid && exp_q.size() == 0) Go = 1'b1;
    end
    chk("batch_done", Done, 1);
    chk("batch_busy", Busy, 0);
    chk("strobes_left", exp_q.size(), 0);
    chk("dutreset_pulses", rst_rises, exp_rises);
    chk("dutreset_cycles", rst_cycles, 2*exp_rises);
    exp_q.delete();

    if (go_at_done) begin
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("late_go_busy", Busy, 0);
        chk("late_go_dutreset", DutReset, 0);
      end
    end
  endtask

  initial begin
    // batch 0: normal acks at RUN cycles 6, 11, 2
    vecs[0]  = '{6,  1'b0, 2'd0, 16'd5,  1'b0};
    vecs[1]  = '{11, 1'b0, 2'd1, 16'd10, 1'b0};
    vecs[2]  = '{2,  1'b0, 2'd2, 16'd1,  1'b0};
    // batch 1: program 1 hangs
    vecs[3]  = '{4,  1'b0, 2'd0, 16'd3,  1'b0};
    vecs[4]  = '{0,  1'b0, 2'd1, 16'd20, 1'b1};
    vecs[5]  = '{3,  1'b0, 2'd2, 16'd2,  1'b0};
    // batch 2: Ack left high into the next program's start
    vecs[6]  = '{2,  1'b0, 2'd0, 16'd1,  1'b0};
    vecs[7]  = '{2,  1'b1, 2'd1, 16'd1,  1'b0};
    vecs[8]  = '{2,  1'b1, 2'd2, 16'd1,  1'b0};
    // batch 3: Ack stuck high (processor model forced)
    vecs[9]  = '{0,  1'b0, 2'd0, 16'd1,  1'b0};
    vecs[10] = '{0,  1'b0, 2'd1, 16'd1,  1'b0};
    vecs[11] = '{0,  1'b0, 2'd2, 16'd1,  1'b0};
    // batch 4: last program hangs
    vecs[12] = '{5,  1'b0, 2'd0, 16'd4,  1'b0};
    vecs[13] = '{7,  1'b0, 2'd1, 16'd6,  1'b0};
    vecs[14] = '{0,  1'b0, 2'd2, 16'd20, 1'b1};

    // ---- power-on reset ----
    #2 Reset = 1'b0;
    #1;
    chk("rst_dutreset", DutReset, 1);
    chk("rst_dutstart", DutStart, 0);
    chk("rst_idx", ProgIdx, 0);
    chk("rst_ct", CycleCt, 0);
    chk("rst_valid", CycleValid, 0);
    chk("rst_timedout", TimedOut, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    repeat (3) tick();
    Reset = 1'b1;
    tick();
    chk("idle_dutreset", DutReset, 0);
    chk("idle_busy", Busy, 0);

    // ---- table-driven batches ----
    for (int b = 0; b < NB; b++) begin
      ack_force = (b == 3);
      // batch 0 also pulses Go mid-RUN and again as Done rises
      run_batch(b, (b == 0) ? 5 : -1, b == 0);
      if (b == 3) begin
        chk("stuck_start_cycle", first_start_cyc - go_cyc, 3);
        chk("stuck_valid_cycle", first_valid_cyc - go_cyc, 6);
      end
      ack_force = 1'b0;
      tick();
    end

    // ---- reset during RUN of program 1 ----
    exp_q.delete();
    for (int p = 0; p < NP; p++) begin
      cur[p] = vecs[p];
      exp_q.push_back({vecs[p].idx, vecs[p].ct, vecs[p].to});
    end
    have_last = 1'b0;
    Go = 1'b1;
    tick();
    Go = 1'b0;
    for (int i = 0; i < 200 && exp_q.size() > 2; i++) tick();
    chk("abort_first_strobe_seen", exp_q.size(), 2);
    repeat (4) tick();
    chk("abort_pre_idx", ProgIdx, 1);
    chk("abort_pre_busy", Busy, 1);
    exp_q.delete();
    #2 Reset = 1'b0;
    #1;
    chk("abort_dutreset", DutReset, 1);
    chk("abort_dutstart", DutStart, 0);
    chk("abort_idx", ProgIdx, 0);
    chk("abort_ct", CycleCt, 0);
    chk("abort_valid", CycleValid, 0);
    chk("abort_timedout", TimedOut, 0);
    chk("abort_busy", Busy, 0);
    chk("abort_done", Done, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_hold_valid", CycleValid, 0);
    end
    Reset = 1'b1;
    tick();
    chk("abort_idle_dutreset", DutReset, 0);
    run_batch(0, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
